// File: rtl/nmr_phase_pkg.sv
// Shared phase codes, FSM state type and phase-code validity helper
// for the NMR phase-cycling sequencer and its phase decoder.
package nmr_phase_pkg;

  localparam logic [4:0] PH_0   = 5'd0;
  localparam logic [4:0] PH_90  = 5'd9;
  localparam logic [4:0] PH_180 = 5'd18;
  localparam logic [4:0] PH_270 = 5'd27;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  function automatic logic is_valid_phase(
    input logic [4:0] p
  );
    return (p == PH_0)   || (p == PH_90) ||
           (p == PH_180) || (p == PH_270);
  endfunction

endpackage

// File: rtl/phase_cycle_sequencer_if.sv
// Host/controller <-> sequencer bundle: run/scan handshake, table
// config port, error clear, and the phase outputs toward the DAC.
interface phase_cycle_sequencer_if #(
  parameter int N_PULSES = 2,
  parameter int N_STEPS  = 4,
  parameter int STEP_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
);

  logic                  run;
  logic                  cfg_we;
  logic [STEP_W-1:0]     cfg_addr;
  logic [5*N_PULSES-1:0] cfg_data;
  logic [STEP_W:0]       cfg_n_steps;
  logic                  scan_start;
  logic                  scan_done;
  logic                  clear_err;
  logic [5*N_PULSES-1:0] phase_decimal;
  logic [2*N_PULSES-1:0] phase_binary;
  logic                  phase_valid;
  logic [STEP_W-1:0]     step_idx;
  logic                  cycle_done;
  logic                  cfg_err;
  logic                  overrun;

  modport master (
    output run, cfg_we, cfg_addr, cfg_data,
    output cfg_n_steps, scan_start, scan_done,
    output clear_err,
    input  phase_decimal, phase_binary,
    input  phase_valid, step_idx, cycle_done,
    input  cfg_err, overrun
  );

  modport slave (
    input  run, cfg_we, cfg_addr, cfg_data,
    input  cfg_n_steps, scan_start, scan_done,
    input  clear_err,
    output phase_decimal, phase_binary,
    output phase_valid, step_idx, cycle_done,
    output cfg_err, overrun
  );

endinterface

// File: rtl/phase_decoder.sv
// Maps decimal phase codes (0/9/18/27) to 2-bit Gray DAC selects.
// Ports: phase_decimal_i (5 bits/pulse), phase_binary_o (2 bits/pulse).
module phase_decoder
  import nmr_phase_pkg::*;
#(
  parameter int N_phases = 2
) (
  input  logic [5*N_phases-1:0] phase_decimal_i,
  output logic [2*N_phases-1:0] phase_binary_o
);

  always_comb begin
    phase_binary_o = '1;
    for (int i = 0; i < N_phases; i++) begin
      case (phase_decimal_i[5*i +: 5])
        PH_0:    phase_binary_o[2*i +: 2] = 2'b11;
        PH_90:   phase_binary_o[2*i +: 2] = 2'b10;
        PH_180:  phase_binary_o[2*i +: 2] = 2'b00;
        PH_270:  phase_binary_o[2*i +: 2] = 2'b01;
        default: phase_binary_o[2*i +: 2] = 2'b11;
      endcase
    end
  end

endmodule

// File: rtl/phase_table.sv
// Phase-cycle table: N_STEPS entries, one write port, comb read port.
// Ports: clk, rst, we_i/waddr_i/wdata_i, raddr_i, rdata_o.
module phase_table #(
  parameter int N_STEPS = 4,
  parameter int W       = 10,
  parameter int AW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [N_STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STEPS; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/phase_cycle_sequencer.sv
// Steps the phase-cycling table once per scan and holds phases.
// Ports: clk, rst, bus (slave: run/scan/cfg in, phases/flags out).
module phase_cycle_sequencer
  import nmr_phase_pkg::*;
#(
  parameter int N_PULSES = 2,
  parameter int N_STEPS  = 4,
  parameter int STEP_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input logic clk,
  input logic rst,
  phase_cycle_sequencer_if.slave bus
);

  localparam int W = 5 * N_PULSES;
  localparam logic [STEP_W:0] NMAX = (STEP_W+1)'(N_STEPS);

  state_t            state_q, state_d;
  logic [W-1:0]      dec_q, dec_d;
  logic              valid_q, valid_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              cyc_q, cyc_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic              data_ok;
  logic              addr_ok;
  logic              tbl_we;
  logic              err_ev;
  logic              ovr_ev;
  logic [W-1:0]      rd_data;
  logic [STEP_W:0]   eff_n;
  logic [STEP_W:0]   nxt;

  phase_table #(
    .N_STEPS (N_STEPS),
    .W       (W),
    .AW      (STEP_W)
  ) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .we_i    (tbl_we),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_data),
    .raddr_i (step_q),
    .rdata_o (rd_data)
  );

  phase_decoder #(
    .N_phases (N_PULSES)
  ) u_dec (
    .phase_decimal_i (dec_q),
    .phase_binary_o  (bus.phase_binary)
  );

  always_comb begin
    data_ok = 1'b1;
    for (int i = 0; i < N_PULSES; i++)
      if (!is_valid_phase(bus.cfg_data[5*i +: 5]))
        data_ok = 1'b0;
  end

  assign addr_ok = {1'b0, bus.cfg_addr} < NMAX;
  assign tbl_we  = bus.cfg_we && (state_q == IDLE)
                && addr_ok && data_ok;
  assign err_ev  = bus.cfg_we && !tbl_we;

  // Cycle length is re-sampled at every advance; zero means one step.
  always_comb begin
    if (bus.cfg_n_steps == '0)
      eff_n = (STEP_W+1)'(1);
    else if (bus.cfg_n_steps > NMAX)
      eff_n = NMAX;
    else
      eff_n = bus.cfg_n_steps;
    nxt = {1'b0, step_q} + (STEP_W+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    step_d  = step_q;
    cyc_d   = 1'b0;
    ovr_ev  = 1'b0;
    if (!bus.run) begin
      state_d = IDLE;
      valid_d = 1'b0;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.scan_start) begin
            dec_d   = rd_data;
            valid_d = 1'b1;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          ovr_ev = bus.scan_start;
          if (bus.scan_done) begin
            valid_d = 1'b0;
            state_d = IDLE;
            if (nxt >= eff_n) begin
              step_d = '0;
              cyc_d  = 1'b1;
            end else begin
              step_d = nxt[STEP_W-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    err_d = err_ev | (err_q & ~bus.clear_err);
    ovr_d = ovr_ev | (ovr_q & ~bus.clear_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.phase_decimal = dec_q;
  assign bus.phase_valid   = valid_q;
  assign bus.step_idx      = step_q;
  assign bus.cycle_done    = cyc_q;
  assign bus.cfg_err       = err_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_phase_cycle_sequencer.sv
// Directed bench: phase codes per scan checked via scoreboard queue,
// step/flag behaviour checked inline with immediate assertions.
module tb_phase_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [3:0] exp_q[$];
  logic       prev_v = 1'b0;

  always #5 clk = ~clk;

  phase_cycle_sequencer_if #(.N_PULSES(2), .N_STEPS(4)) bus();

  phase_cycle_sequencer #(.N_PULSES(2), .N_STEPS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected Gray word per rising phase_valid.
  always @(negedge clk) begin
    if (!rst && bus.phase_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(bus.phase_binary), 32'hdead);
      end else begin
        check("sb_phase", 32'(bus.phase_binary), 32'(exp_q.pop_front()));
      end
    end
    prev_v <= bus.phase_valid;
  end

  function automatic logic [9:0] pk(input logic [4:0] p0,
                                    input logic [4:0] p1);
    return {p1, p0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] e);
    bus.scan_start = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.scan_start = 1'b0;
  endtask

  task automatic end_scan();
    bus.scan_done = 1'b1;
    tick();
    bus.scan_done = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [9:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  logic [3:0] g4 [4];
  logic [3:0] g2 [4];

  initial begin
    g4[0] = 4'b1111; g4[1] = 4'b1010;
    g4[2] = 4'b0000; g4[3] = 4'b0101;
    bus.run = 0; bus.cfg_we = 0; bus.cfg_addr = 0;
    bus.cfg_data = 0; bus.cfg_n_steps = 4;
    bus.scan_start = 0; bus.scan_done = 0; bus.clear_err = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(bus.phase_valid), 0);
    check("rst_step", 32'(bus.step_idx), 0);
    check("rst_cyc", 32'(bus.cycle_done), 0);
    check("rst_err", 32'(bus.cfg_err), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    check("rst_dec", 32'(bus.phase_decimal), 0);
    check("rst_bin", 32'(bus.phase_binary), 32'hf);

    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    check("run0_ignored", 32'(bus.phase_valid), 0);

    bus.run = 1'b1;
    start_scan(4'b1111);
    check("t1_valid", 32'(bus.phase_valid), 1);
    check("t1_dec", 32'(bus.phase_decimal), 0);
    end_scan();
    check("t1_valid_fall", 32'(bus.phase_valid), 0);
    check("t1_step", 32'(bus.step_idx), 1);
    check("t1_cyc", 32'(bus.cycle_done), 0);

    wr(0, pk(0, 0));
    wr(1, pk(9, 9));
    wr(2, pk(18, 18));
    wr(3, pk(27, 27));
    check("t2_wr_err", 32'(bus.cfg_err), 0);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    check("t2_step0", 32'(bus.step_idx), 0);
    for (int i = 0; i < 4; i++) begin
      start_scan(g4[i]);
      end_scan();
      check("t2_cyc", 32'(bus.cycle_done), (i == 3) ? 1 : 0);
      check("t2_step", 32'(bus.step_idx), (i + 1) % 4);
    end
    tick();
    check("t2_cyc_pulse", 32'(bus.cycle_done), 0);
    start_scan(4'b1111);
    end_scan();
    check("t2_step5", 32'(bus.step_idx), 1);

    wr(1, pk(5, 9));
    check("t3_err", 32'(bus.cfg_err), 1);
    bus.clear_err = 1'b1;
    wr(1, pk(9, 5));
    bus.clear_err = 1'b0;
    check("t3_err_wins", 32'(bus.cfg_err), 1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("t3_clear", 32'(bus.cfg_err), 0);
    wr(3, pk(27, 27));
    wr(2'd0, pk(0, 0));
    check("t3_ok_err", 32'(bus.cfg_err), 0);

    start_scan(4'b1010);
    wr(1, pk(18, 18));
    check("t4_err", 32'(bus.cfg_err), 1);
    check("t4_dec", 32'(bus.phase_decimal), 32'(pk(9, 9)));
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    check("t4_ovr", 32'(bus.overrun), 1);
    check("t4_hold", 32'(bus.phase_decimal), 32'(pk(9, 9)));
    check("t4_still_valid", 32'(bus.phase_valid), 1);

    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("t5_ovr_clr", 32'(bus.overrun), 0);
    bus.scan_start = 1'b1;
    bus.scan_done  = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.scan_done  = 1'b0;
    check("t5_valid", 32'(bus.phase_valid), 0);
    check("t5_step", 32'(bus.step_idx), 2);
    check("t5_ovr", 32'(bus.overrun), 1);
    tick();
    check("t5_idle", 32'(bus.phase_valid), 0);

    start_scan(4'b0000);
    bus.run = 1'b0;
    bus.scan_done = 1'b1;
    tick();
    bus.scan_done = 1'b0;
    check("t6_abort_valid", 32'(bus.phase_valid), 0);
    check("t6_abort_step", 32'(bus.step_idx), 0);
    check("t6_abort_cyc", 32'(bus.cycle_done), 0);
    check("t6_flags_kept", 32'(bus.overrun), 1);
    bus.run = 1'b1;

    wr(0, pk(27, 27));
    check("t6_cur_wr", 32'(bus.cfg_err), 0);
    start_scan(4'b0101);
    end_scan();
    check("t6_step1", 32'(bus.step_idx), 1);

    bus.cfg_n_steps = 0;
    start_scan(4'b1010);
    end_scan();
    check("t6_n0_wrap", 32'(bus.step_idx), 0);
    check("t6_n0_cyc", 32'(bus.cycle_done), 1);
    for (int i = 0; i < 2; i++) begin
      start_scan(4'b0101);
      end_scan();
      check("t6_n0_step", 32'(bus.step_idx), 0);
      check("t6_n0_cyc_each", 32'(bus.cycle_done), 1);
    end

    g2[0] = 4'b0101; g2[1] = 4'b1010;
    g2[2] = 4'b0000; g2[3] = 4'b0101;
    bus.cfg_n_steps = 7;
    for (int i = 0; i < 4; i++) begin
      start_scan(g2[i]);
      end_scan();
      check("t6_n7_step", 32'(bus.step_idx), (i + 1) % 4);
      check("t6_n7_cyc", 32'(bus.cycle_done), (i == 3) ? 1 : 0);
    end

    tick();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
